// File: rtl/net_passthrough_pkg.sv
// Shared types, register map offsets and helpers for the N-channel network passthrough.
// The optional byte counter is enabled with NET_PASSTHROUGH_BYTE_COUNT_EN.
package net_passthrough_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PASS    = 2'd1,
    DISCARD = 2'd2,
    DROP    = 2'd3
  } chan_state_e;

  localparam int CNT_W       = 32;
  localparam int REG_ID      = 'h00;
  localparam int CHAN_BASE   = 'h10;
  localparam int CHAN_STRIDE = 'h10;
  localparam int OFF_CTRL    = 'h0;
  localparam int OFF_PKT     = 'h4;
  localparam int OFF_TRUNC   = 'h8;
  localparam int OFF_DROP    = 'hC;
  localparam int BYTE_BASE   = 'h90;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  function automatic int max_beats(input int len_bytes, input int bus_width);
    return (len_bytes + bus_width / 8 - 1) / (bus_width / 8);
  endfunction

  // Saturating add: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] a);
    logic [CNT_W:0] s;
    s = {1'b0, v} + {1'b0, a};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/net_passthrough_chan.sv
// One passthrough channel: packet gate FSM, max-length truncation, 2-entry output skid
// and statistics counters (byte counter only with NET_PASSTHROUGH_BYTE_COUNT_EN).
module net_passthrough_chan
  import net_passthrough_pkg::*;
#(
  parameter int BUS_W  = 64,
  parameter int ID_W   = 3,
  parameter int DEST_W = 1,
  parameter int MAX_B  = 191
) (
  input  logic              clk,
  input  logic              areset,
  input  logic [BUS_W-1:0]  in_tdata,
  input  logic [ID_W-1:0]   in_tdest,
  input  logic [BUS_W/8-1:0] in_tkeep,
  input  logic              in_tlast,
  input  logic              in_tvalid,
  output logic              in_tready,
  output logic [BUS_W-1:0]  out_tdata,
  output logic [ID_W-1:0]   out_tid,
  output logic [DEST_W-1:0] out_tdest,
  output logic [BUS_W/8-1:0] out_tkeep,
  output logic              out_tlast,
  output logic              out_tvalid,
  input  logic              out_tready,
  input  logic              enable,
  input  logic [ID_W-1:0]   tid,
  input  logic              pkt_clr,
  input  logic              trunc_clr,
  input  logic              drop_clr,
  input  logic              byte_clr,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  trunc_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic [CNT_W-1:0]  byte_count,
  output chan_state_e       state_dbg
);

  localparam int KEEP_W = BUS_W / 8;
  localparam int BEAT_W = $clog2(MAX_B + 1);
  localparam int ENT_W  = 1 + ID_W + DEST_W + KEEP_W + BUS_W;

  chan_state_e      state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d, beat_num;
  logic [ENT_W-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q;
  logic             sink_state, in_fire, hit_max, fwd, trunc, push, pop;
  logic             pkt_inc, trunc_inc, drop_inc;
  logic [CNT_W-1:0] pkt_q, trunc_q, drop_q;
  logic             unused_dest;

  assign unused_dest = ^in_tdest;
  assign state_dbg   = state_q;
  assign sink_state  = (state_q == DISCARD) || (state_q == DROP);
  // Sink states keep draining the input even while the skid is backed up.
  assign in_tready   = !areset && ((count_q != 2'd2) || sink_state);
  assign in_fire     = in_tvalid && in_tready;
  assign beat_num    = (state_q == IDLE) ? BEAT_W'(1) : beat_q + BEAT_W'(1);
  assign hit_max     = (beat_num == BEAT_W'(MAX_B)) && !in_tlast;

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    fwd       = 1'b0;
    trunc     = 1'b0;
    pkt_inc   = 1'b0;
    trunc_inc = 1'b0;
    drop_inc  = 1'b0;
    if (in_fire) begin
      if (state_q == PASS || (state_q == IDLE && enable)) begin
        fwd    = 1'b1;
        beat_d = beat_num;
        if (in_tlast) begin
          state_d = IDLE;
          pkt_inc = 1'b1;
        end else if (hit_max) begin
          trunc     = 1'b1;
          trunc_inc = 1'b1;
          state_d   = DISCARD;
        end else begin
          state_d = PASS;
        end
      end else if (state_q == IDLE) begin
        state_d  = in_tlast ? IDLE : DROP;
        drop_inc = in_tlast;
      end else if (in_tlast) begin
        state_d  = IDLE;
        drop_inc = (state_q == DROP);
      end
    end
  end

  assign push       = fwd;
  assign pop        = out_tvalid && out_tready;
  assign out_tvalid = (count_q != 2'd0);
  assign {out_tlast, out_tid, out_tdest, out_tkeep, out_tdata} = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (areset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= {in_tlast | trunc, tid, in_tdest[DEST_W-1:0], in_tkeep, in_tdata};
      wr_ptr_q <= wr_ptr_q ^ push;
      rd_ptr_q <= rd_ptr_q ^ pop;
      count_q  <= count_q + 2'(push) - 2'(pop);
    end
  end

  // A register write clears a counter even if it would increment in the same cycle.
  always_ff @(posedge clk) begin
    if (areset) begin
      pkt_q   <= '0;
      trunc_q <= '0;
      drop_q  <= '0;
    end else begin
      if (pkt_clr) pkt_q <= '0;
      else if (pkt_inc) pkt_q <= sat_add(pkt_q, CNT_W'(1));
      if (trunc_clr) trunc_q <= '0;
      else if (trunc_inc) trunc_q <= sat_add(trunc_q, CNT_W'(1));
      if (drop_clr) drop_q <= '0;
      else if (drop_inc) drop_q <= sat_add(drop_q, CNT_W'(1));
    end
  end

  assign pkt_count   = pkt_q;
  assign trunc_count = trunc_q;
  assign drop_count  = drop_q;

`ifdef NET_PASSTHROUGH_BYTE_COUNT_EN
  logic [CNT_W-1:0] keep_pop, byte_q;

  always_comb begin
    keep_pop = '0;
    for (int i = 0; i < KEEP_W; i++) keep_pop = keep_pop + CNT_W'(in_tkeep[i]);
  end

  always_ff @(posedge clk) begin
    if (areset) byte_q <= '0;
    else if (byte_clr) byte_q <= '0;
    else if (push) byte_q <= sat_add(byte_q, keep_pop);
  end

  assign byte_count = byte_q;
`else
  logic unused_byte_clr;
  assign unused_byte_clr = byte_clr;
  assign byte_count      = '0;
`endif

endmodule

// File: rtl/net_passthrough_nport.sv
// N-channel AXI-Stream passthrough with an AXI-Lite control/statistics slave.
// Define NET_PASSTHROUGH_BYTE_COUNT_EN to add per-channel byte counters at 0x90 + 4*c.
module net_passthrough_nport
  import net_passthrough_pkg::*;
#(
  parameter int NUM_CHAN          = 2,
  parameter int AXIS_BUS_WIDTH    = 64,
  parameter int AXIS_ID_WIDTH     = 3,
  parameter int AXIS_DEST_WIDTH   = 1,
  parameter int MAX_PACKET_LENGTH = 1522,
  parameter int CTRL_ADDR_WIDTH   = 8
) (
  input  logic                                  aclk,
  input  logic                                  areset,
  input  logic [NUM_CHAN*AXIS_BUS_WIDTH-1:0]    axis_in_tdata,
  input  logic [NUM_CHAN*AXIS_ID_WIDTH-1:0]     axis_in_tdest,
  input  logic [NUM_CHAN*AXIS_BUS_WIDTH/8-1:0]  axis_in_tkeep,
  input  logic [NUM_CHAN-1:0]                   axis_in_tlast,
  input  logic [NUM_CHAN-1:0]                   axis_in_tvalid,
  output logic [NUM_CHAN-1:0]                   axis_in_tready,
  output logic [NUM_CHAN*AXIS_BUS_WIDTH-1:0]    axis_out_tdata,
  output logic [NUM_CHAN*AXIS_ID_WIDTH-1:0]     axis_out_tid,
  output logic [NUM_CHAN*AXIS_DEST_WIDTH-1:0]   axis_out_tdest,
  output logic [NUM_CHAN*AXIS_BUS_WIDTH/8-1:0]  axis_out_tkeep,
  output logic [NUM_CHAN-1:0]                   axis_out_tlast,
  output logic [NUM_CHAN-1:0]                   axis_out_tvalid,
  input  logic [NUM_CHAN-1:0]                   axis_out_tready,
  input  logic [CTRL_ADDR_WIDTH-1:0]            ctrl_awaddr,
  input  logic                                  ctrl_awvalid,
  output logic                                  ctrl_awready,
  input  logic [31:0]                           ctrl_wdata,
  input  logic [3:0]                            ctrl_wstrb,
  input  logic                                  ctrl_wvalid,
  output logic                                  ctrl_wready,
  output logic [1:0]                            ctrl_bresp,
  output logic                                  ctrl_bvalid,
  input  logic                                  ctrl_bready,
  input  logic [CTRL_ADDR_WIDTH-1:0]            ctrl_araddr,
  input  logic                                  ctrl_arvalid,
  output logic                                  ctrl_arready,
  output logic [31:0]                           ctrl_rdata,
  output logic [1:0]                            ctrl_rresp,
  output logic                                  ctrl_rvalid,
  input  logic                                  ctrl_rready,
  output logic [NUM_CHAN*2-1:0]                 dbg_chan_state
);

  localparam int AW        = CTRL_ADDR_WIDTH;
  localparam int BW        = AXIS_BUS_WIDTH;
  localparam int KW        = AXIS_BUS_WIDTH / 8;
  localparam int IW        = AXIS_ID_WIDTH;
  localparam int DW        = AXIS_DEST_WIDTH;
  localparam int MAX_BEATS = max_beats(MAX_PACKET_LENGTH, AXIS_BUS_WIDTH);

  // AXI-Lite handshakes: a channel transfers on the edge where valid and ready are both high;
  // masters hold valid and payload until then, and ready here is a registered one-cycle pulse.
  logic             aw_rdy_q, bvalid_q, ar_rdy_q, rvalid_q;
  logic [31:0]      rdata_q, rd_val;
  logic             wr_fire, rd_fire;
  logic [AW-1:0]    wr_addr, rd_addr;
  logic [CNT_W-1:0] pkt_cnt [NUM_CHAN];
  logic [CNT_W-1:0] trunc_cnt [NUM_CHAN];
  logic [CNT_W-1:0] drop_cnt [NUM_CHAN];
  logic [CNT_W-1:0] byte_cnt [NUM_CHAN];
  logic [31:0]      ctrl_word [NUM_CHAN];
  logic             unused_ctrl;

  assign unused_ctrl  = ^{ctrl_awaddr[1:0], ctrl_araddr[1:0], ctrl_wdata, ctrl_wstrb};
  assign wr_addr      = {ctrl_awaddr[AW-1:2], 2'b00};
  assign rd_addr      = {ctrl_araddr[AW-1:2], 2'b00};
  assign wr_fire      = ctrl_awvalid && ctrl_wvalid && aw_rdy_q;
  assign rd_fire      = ctrl_arvalid && ar_rdy_q;
  assign ctrl_awready = aw_rdy_q;
  assign ctrl_wready  = aw_rdy_q;
  assign ctrl_bvalid  = bvalid_q;
  assign ctrl_bresp   = RESP_OKAY;
  assign ctrl_arready = ar_rdy_q;
  assign ctrl_rvalid  = rvalid_q;
  assign ctrl_rdata   = rdata_q;
  assign ctrl_rresp   = RESP_OKAY;

  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_rdy_q <= 1'b0;
      bvalid_q <= 1'b0;
    end else begin
      if (wr_fire) begin
        aw_rdy_q <= 1'b0;
        bvalid_q <= 1'b1;
      end else if (ctrl_awvalid && ctrl_wvalid && !bvalid_q && !aw_rdy_q) begin
        aw_rdy_q <= 1'b1;
      end
      if (bvalid_q && ctrl_bready) bvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      ar_rdy_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (rd_fire) begin
        ar_rdy_q <= 1'b0;
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
      end else if (ctrl_arvalid && !rvalid_q && !ar_rdy_q) begin
        ar_rdy_q <= 1'b1;
      end
      if (rvalid_q && ctrl_rready) rvalid_q <= 1'b0;
    end
  end

  always_comb begin
    rd_val = '0;
    if (rd_addr == AW'(REG_ID)) rd_val = 32'(NUM_CHAN);
    for (int c = 0; c < NUM_CHAN; c++) begin
      if (rd_addr == AW'(CHAN_BASE + CHAN_STRIDE * c + OFF_CTRL))  rd_val = ctrl_word[c];
      if (rd_addr == AW'(CHAN_BASE + CHAN_STRIDE * c + OFF_PKT))   rd_val = pkt_cnt[c];
      if (rd_addr == AW'(CHAN_BASE + CHAN_STRIDE * c + OFF_TRUNC)) rd_val = trunc_cnt[c];
      if (rd_addr == AW'(CHAN_BASE + CHAN_STRIDE * c + OFF_DROP))  rd_val = drop_cnt[c];
      if (rd_addr == AW'(BYTE_BASE + 4 * c))                       rd_val = byte_cnt[c];
    end
  end

  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
    localparam int BASE = CHAN_BASE + CHAN_STRIDE * c;
    logic          en_q;
    logic [IW-1:0] tid_q;
    logic          ctrl_wr;
    chan_state_e   state;

    assign ctrl_wr      = wr_fire && (wr_addr == AW'(BASE + OFF_CTRL));
    assign ctrl_word[c] = 32'({tid_q, 7'b0, en_q});
    assign dbg_chan_state[2*c +: 2] = state;

    always_ff @(posedge aclk) begin
      if (areset) begin
        en_q  <= 1'b1;
        tid_q <= IW'(c);
      end else if (ctrl_wr) begin
        if (ctrl_wstrb[0]) en_q <= ctrl_wdata[0];
        for (int i = 0; i < IW; i++)
          if (ctrl_wstrb[(8 + i) / 8]) tid_q[i] <= ctrl_wdata[8 + i];
      end
    end

    net_passthrough_chan #(
      .BUS_W (BW),
      .ID_W  (IW),
      .DEST_W(DW),
      .MAX_B (MAX_BEATS)
    ) u_chan (
      .clk        (aclk),
      .areset     (areset),
      .in_tdata   (axis_in_tdata[c*BW +: BW]),
      .in_tdest   (axis_in_tdest[c*IW +: IW]),
      .in_tkeep   (axis_in_tkeep[c*KW +: KW]),
      .in_tlast   (axis_in_tlast[c]),
      .in_tvalid  (axis_in_tvalid[c]),
      .in_tready  (axis_in_tready[c]),
      .out_tdata  (axis_out_tdata[c*BW +: BW]),
      .out_tid    (axis_out_tid[c*IW +: IW]),
      .out_tdest  (axis_out_tdest[c*DW +: DW]),
      .out_tkeep  (axis_out_tkeep[c*KW +: KW]),
      .out_tlast  (axis_out_tlast[c]),
      .out_tvalid (axis_out_tvalid[c]),
      .out_tready (axis_out_tready[c]),
      .enable     (en_q),
      .tid        (tid_q),
      .pkt_clr    (wr_fire && (wr_addr == AW'(BASE + OFF_PKT))),
      .trunc_clr  (wr_fire && (wr_addr == AW'(BASE + OFF_TRUNC))),
      .drop_clr   (wr_fire && (wr_addr == AW'(BASE + OFF_DROP))),
      .byte_clr   (wr_fire && (wr_addr == AW'(BYTE_BASE + 4 * c))),
      .pkt_count  (pkt_cnt[c]),
      .trunc_count(trunc_cnt[c]),
      .drop_count (drop_cnt[c]),
      .byte_count (byte_cnt[c]),
      .state_dbg  (state)
    );
  end

endmodule

// File: tb/tb_net_passthrough_nport.sv
// Scoreboard bench for net_passthrough_nport (2 channels, 64-bit, MAX_BEATS=191).
`timescale 1ns/1ps
module tb_net_passthrough_nport;
  localparam int NC = 2, BW = 64, KW = 8, IW = 3, DW = 1, AW = 8, TMO = 2000;
  localparam int EW = 1 + IW + DW + KW + BW;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  logic [NC*BW-1:0] axis_in_tdata, axis_out_tdata;
  logic [NC*IW-1:0] axis_in_tdest, axis_out_tid;
  logic [NC*DW-1:0] axis_out_tdest;
  logic [NC*KW-1:0] axis_in_tkeep, axis_out_tkeep;
  logic [NC-1:0]    axis_in_tlast, axis_in_tvalid, axis_in_tready;
  logic [NC-1:0]    axis_out_tlast, axis_out_tvalid, axis_out_tready;
  logic [AW-1:0]    ctrl_awaddr, ctrl_araddr;
  logic             ctrl_awvalid, ctrl_awready, ctrl_wvalid, ctrl_wready;
  logic             ctrl_bvalid, ctrl_bready, ctrl_arvalid, ctrl_arready;
  logic             ctrl_rvalid, ctrl_rready;
  logic [31:0]      ctrl_wdata, ctrl_rdata;
  logic [3:0]       ctrl_wstrb;
  logic [1:0]       ctrl_bresp, ctrl_rresp;
  logic [NC*2-1:0]  dbg_chan_state;

  logic [BW-1:0] in_data [NC];
  logic [IW-1:0] in_dest [NC];
  logic [KW-1:0] in_keep [NC];
  logic          in_last [NC];
  logic          in_valid [NC];
  logic          out_rdy0, out_rdy1, rand_rdy1;
  logic [IW-1:0] exp_tid [NC];

  always_comb begin
    for (int c = 0; c < NC; c++) begin
      axis_in_tdata[c*BW +: BW] = in_data[c];
      axis_in_tdest[c*IW +: IW] = in_dest[c];
      axis_in_tkeep[c*KW +: KW] = in_keep[c];
      axis_in_tlast[c]          = in_last[c];
      axis_in_tvalid[c]         = in_valid[c];
    end
    axis_out_tready = {out_rdy1, out_rdy0};
  end

  net_passthrough_nport dut (
    .aclk(aclk), .areset(areset),
    .axis_in_tdata(axis_in_tdata), .axis_in_tdest(axis_in_tdest), .axis_in_tkeep(axis_in_tkeep),
    .axis_in_tlast(axis_in_tlast), .axis_in_tvalid(axis_in_tvalid), .axis_in_tready(axis_in_tready),
    .axis_out_tdata(axis_out_tdata), .axis_out_tid(axis_out_tid), .axis_out_tdest(axis_out_tdest),
    .axis_out_tkeep(axis_out_tkeep), .axis_out_tlast(axis_out_tlast),
    .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready),
    .ctrl_awaddr(ctrl_awaddr), .ctrl_awvalid(ctrl_awvalid), .ctrl_awready(ctrl_awready),
    .ctrl_wdata(ctrl_wdata), .ctrl_wstrb(ctrl_wstrb), .ctrl_wvalid(ctrl_wvalid),
    .ctrl_wready(ctrl_wready), .ctrl_bresp(ctrl_bresp), .ctrl_bvalid(ctrl_bvalid),
    .ctrl_bready(ctrl_bready), .ctrl_araddr(ctrl_araddr), .ctrl_arvalid(ctrl_arvalid),
    .ctrl_arready(ctrl_arready), .ctrl_rdata(ctrl_rdata), .ctrl_rresp(ctrl_rresp),
    .ctrl_rvalid(ctrl_rvalid), .ctrl_rready(ctrl_rready), .dbg_chan_state(dbg_chan_state)
  );

  // Scoreboard: entries are {tlast, tid, tdest, tkeep, tdata}
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  int checks = 0;
  int errors = 0;
  int pkt_id = 0;

  task automatic check_val(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic push_exp(input int ch, input logic [EW-1:0] v);
    if (ch == 0) exp_q0.push_back(v);
    else exp_q1.push_back(v);
  endtask

  task automatic mon_beat(input int ch, input logic [EW-1:0] got);
    logic [EW-1:0] e;
    if ((ch == 0 && exp_q0.size() == 0) || (ch == 1 && exp_q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_beat ch%0d got %h exp none", ch, got);
    end else begin
      e = (ch == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check_val($sformatf("beat_ch%0d", ch), 128'(got), 128'(e));
    end
  endtask

  initial begin
    forever begin
      @(negedge aclk);
      if (!areset)
        for (int c = 0; c < NC; c++)
          if (axis_out_tvalid[c] && axis_out_tready[c])
            mon_beat(c, {axis_out_tlast[c], axis_out_tid[c*IW +: IW], axis_out_tdest[c*DW +: DW],
                         axis_out_tkeep[c*KW +: KW], axis_out_tdata[c*BW +: BW]});
    end
  end

  initial begin
    forever begin
      @(posedge aclk);
      #1 out_rdy1 = rand_rdy1 ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_beat(input int ch, input logic [BW-1:0] d, input logic [KW-1:0] k,
                           input logic l, input logic [IW-1:0] dst, input logic fwd,
                           input logic exp_last);
    int n;
    @(negedge aclk);
    in_data[ch] = d; in_keep[ch] = k; in_last[ch] = l; in_dest[ch] = dst; in_valid[ch] = 1'b1;
    n = 0;
    while (!axis_in_tready[ch] && n < TMO) begin
      @(negedge aclk);
      n++;
    end
    if (n >= TMO) begin
      checks++;
      errors++;
      $display("FAIL in_tready_timeout ch%0d got 0 exp 1", ch);
    end
    @(posedge aclk);
    if (fwd) push_exp(ch, {exp_last, exp_tid[ch], dst[DW-1:0], k, d});
  endtask

  task automatic send_pkt(input int ch, input int n, input logic fwd, input int trunc_at,
                          input logic [KW-1:0] last_keep, input logic send_last);
    int id;
    logic l, f, el;
    id = pkt_id++;
    for (int i = 1; i <= n; i++) begin
      l  = (i == n) && send_last;
      f  = fwd && (trunc_at == 0 || i <= trunc_at);
      el = l || (i == trunc_at);
      send_beat(ch, {16'(16'hA000 + ch), 16'(id), 32'(i)}, (i == n) ? last_keep : 8'hFF,
                l, IW'(i), f, el);
    end
    @(negedge aclk);
    in_valid[ch] = 1'b0;
    in_last[ch]  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < TMO) begin
      @(negedge aclk);
      n++;
    end
    if (n >= TMO) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d/%0d exp 0/0", exp_q0.size(), exp_q1.size());
    end
    repeat (3) @(negedge aclk);
  endtask

  task automatic axil_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge aclk);
    ctrl_awaddr = a; ctrl_wdata = d; ctrl_wstrb = s; ctrl_awvalid = 1'b1; ctrl_wvalid = 1'b1;
    n = 0;
    while (!ctrl_awready && n < 50) begin @(negedge aclk); n++; end
    @(negedge aclk);
    ctrl_awvalid = 1'b0; ctrl_wvalid = 1'b0;
    n = 0;
    while (!ctrl_bvalid && n < 50) begin @(negedge aclk); n++; end
    check_val("bvalid_bresp", {ctrl_bvalid, ctrl_bresp}, 3'b100);
  endtask

  task automatic check_reg(input string name, input logic [AW-1:0] a, input logic [31:0] exp);
    int n;
    @(negedge aclk);
    ctrl_araddr = a; ctrl_arvalid = 1'b1;
    n = 0;
    while (!ctrl_arready && n < 50) begin @(negedge aclk); n++; end
    @(negedge aclk);
    ctrl_arvalid = 1'b0;
    n = 0;
    while (!ctrl_rvalid && n < 50) begin @(negedge aclk); n++; end
    check_val(name, {ctrl_rvalid, ctrl_rresp, ctrl_rdata}, {1'b1, 2'b00, exp});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout exp finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    areset = 1'b1;
    rand_rdy1 = 1'b0; out_rdy0 = 1'b1;
    for (int c = 0; c < NC; c++) begin
      in_data[c] = '0; in_dest[c] = '0; in_keep[c] = '0; in_last[c] = 1'b0; in_valid[c] = 1'b0;
      exp_tid[c] = IW'(c);
    end
    ctrl_awaddr = '0; ctrl_awvalid = 1'b0; ctrl_wdata = '0; ctrl_wstrb = '0; ctrl_wvalid = 1'b0;
    ctrl_bready = 1'b1; ctrl_araddr = '0; ctrl_arvalid = 1'b0; ctrl_rready = 1'b1;
    repeat (3) @(negedge aclk);
    check_val("reset_handshakes", {axis_out_tvalid, axis_in_tready, ctrl_awready, ctrl_wready,
              ctrl_arready, ctrl_bvalid, ctrl_rvalid}, '0);
    check_val("reset_data", {axis_out_tlast, axis_out_tdata, ctrl_rdata}, '0);
    check_val("reset_state", dbg_chan_state, '0);
    areset = 1'b0;

    check_reg("id_reg", 8'h00, 32'd2);
    check_reg("ctrl0_reset", 8'h10, 32'h001);
    check_reg("ctrl1_reset", 8'h20, 32'h101);

    // 3-beat and 2-beat packets, checked beat for beat incl. tid and tdest
    send_pkt(0, 3, 1'b1, 0, 8'h0F, 1'b1);
    send_pkt(1, 2, 1'b1, 0, 8'h01, 1'b1);
    drain();
    check_reg("pkt0_a", 8'h14, 32'd1);
    check_reg("pkt1_a", 8'h24, 32'd1);
`ifdef NET_PASSTHROUGH_BYTE_COUNT_EN
    check_reg("bytes0", 8'h90, 32'd20);
    check_reg("bytes1", 8'h94, 32'd9);
    axil_write(8'h90, 32'h1234, 4'hF);
    check_reg("bytes0_clr", 8'h90, 32'd0);
`else
    check_reg("bytes0_absent", 8'h90, 32'd0);
`endif

    // 200 beats: 191 forwarded with tlast forced on beat 191, 9 swallowed
    send_pkt(0, 200, 1'b1, 191, 8'hFF, 1'b1);
    drain();
    check_reg("trunc0", 8'h18, 32'd1);
    check_reg("pkt0_b", 8'h14, 32'd1);

    // Disable mid-packet: current packet completes, the next one is dropped
    fork
      send_pkt(0, 6, 1'b1, 0, 8'hFF, 1'b1);
      begin repeat (3) @(negedge aclk); axil_write(8'h10, 32'h0, 4'h1); end
    join
    send_pkt(0, 2, 1'b0, 0, 8'hFF, 1'b1);
    drain();
    check_reg("drop0", 8'h1C, 32'd1);
    check_reg("pkt0_c", 8'h14, 32'd2);
    check_reg("ctrl0_dis", 8'h10, 32'h000);
    axil_write(8'h10, 32'h1, 4'h1);
    axil_write(8'h14, 32'hDEAD, 4'hF);
    check_reg("pkt0_clr", 8'h14, 32'd0);
    axil_write(8'h20, 32'h0000_0501, 4'h1);
    check_reg("ctrl1_wstrb", 8'h20, 32'h101);
    axil_write(8'h08, 32'hFFFF_FFFF, 4'hF);
    check_reg("unmapped", 8'h08, 32'd0);

    // Both channels streaming, ch1 with random backpressure
    rand_rdy1 = 1'b1;
    fork
      for (int p = 0; p < 3; p++) send_pkt(0, 20, 1'b1, 0, 8'hFF, 1'b1);
      for (int p = 0; p < 3; p++) send_pkt(1, 20, 1'b1, 0, 8'h03, 1'b1);
    join
    drain();
    rand_rdy1 = 1'b0;
    drain();
    check_reg("pkt0_d", 8'h14, 32'd3);
    check_reg("pkt1_d", 8'h24, 32'd4);

    // Reset with a packet left open, then a single-beat packet
    send_pkt(0, 3, 1'b1, 0, 8'hFF, 1'b0);
    drain();
    @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    check_val("reset_mid_ready", {axis_in_tready, axis_out_tvalid}, '0);
    @(negedge aclk);
    areset = 1'b0;
    check_reg("pkt0_rst", 8'h14, 32'd0);
    check_reg("trunc0_rst", 8'h18, 32'd0);
    check_reg("drop0_rst", 8'h1C, 32'd0);
    check_reg("ctrl0_rst", 8'h10, 32'h001);
    check_reg("pkt1_rst", 8'h24, 32'd0);
    send_pkt(0, 1, 1'b1, 0, 8'h0F, 1'b1);
    drain();
    check_reg("pkt0_e", 8'h14, 32'd1);

    check_val("queues_empty", {32'(exp_q0.size()), 32'(exp_q1.size())}, '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/net_passthrough_nport.md
Name: net_passthrough_nport

Overview:
- Parametrised N-channel network passthrough app for an app region; successor to the fixed 2-port passthrough.
- Per channel: rx AXI-Stream in, tx AXI-Stream out, with a packet-boundary enable/drop gate, forced-tlast truncation at max packet length and a skid buffer on the output.
- Per-channel control and statistics are exposed on an AXI-Lite slave in the same clock domain. Clock-crossing stays outside the block.

Parameters:
- NUM_CHAN, 2, number of channels (1..8)
- AXIS_BUS_WIDTH, 64, tdata width (multiple of 8)
- AXIS_ID_WIDTH, 3, tx tid width and rx tdest width
- AXIS_DEST_WIDTH, 1, tx tdest width (<= AXIS_ID_WIDTH)
- MAX_PACKET_LENGTH, 1522, bytes; MAX_BEATS = ceil(MAX_PACKET_LENGTH / (AXIS_BUS_WIDTH/8))
- CTRL_ADDR_WIDTH, 8, AXI-Lite address width

Ports:
- aclk  in  1  single clock for all interfaces
- areset  in  1  synchronous, active-high reset
- axis_in_tdata  in  NUM_CHAN*AXIS_BUS_WIDTH  packed rx data; channel c at slice c
- axis_in_tdest  in  NUM_CHAN*AXIS_ID_WIDTH  rx dest
- axis_in_tkeep  in  NUM_CHAN*AXIS_BUS_WIDTH/8  byte enables
- axis_in_tlast/tvalid  in  NUM_CHAN  per-channel
- axis_in_tready  out  NUM_CHAN
- axis_out_tdata  out  NUM_CHAN*AXIS_BUS_WIDTH  tx data
- axis_out_tid  out  NUM_CHAN*AXIS_ID_WIDTH  from channel ctrl register
- axis_out_tdest  out  NUM_CHAN*AXIS_DEST_WIDTH  input tdest, low bits
- axis_out_tkeep  out  NUM_CHAN*AXIS_BUS_WIDTH/8
- axis_out_tlast/tvalid  out  NUM_CHAN
- axis_out_tready  in  NUM_CHAN
- ctrl_aw*/w*/b*/ar*/r*  mixed  AXI-Lite: addr CTRL_ADDR_WIDTH, data 32, wstrb 4, resp 2

Behaviour:
- Reset (synchronous, areset=1 at a clock edge):
  - All tvalid, tready, awready, wready, arready, bvalid and rvalid are 0. tlast, tdata and rdata are 0.
  - ctrl.enable=1, ctrl.tid=c, all counters 0, every channel FSM in IDLE, skid buffers empty.
  - Reset mid-packet discards the partial packet; no tlast is emitted.
- Channel FSM:
  - IDLE: on the first accepted beat, sample enable.
    - enable=1 -> forward the beat and go to PASS.
    - enable=0 -> discard and go to DROP.
    - In both cases, a tlast on that beat returns to IDLE.
  - PASS: forward beats and count them.
    - Input tlast -> IDLE, pkt_count++.
    - On beat MAX_BEATS without tlast: emit that beat with tlast=1, trunc_count++, go to DISCARD.
  - DISCARD / DROP: tready=1, beats are not forwarded. Input tlast -> IDLE; in DROP, drop_count++.
  - Enable changes take effect only at a packet boundary.
- Datapath:
  - axis_in_tready = skid not full, or FSM in DROP/DISCARD.
  - 2-entry skid per channel gives 1-cycle latency (accept at N -> out tvalid at N+1) and full throughput.
  - Output holds steady while tvalid=1 and tready=0.
- Counters: 32-bit, saturate at 0xFFFFFFFF. A write of any value clears the counter.
- AXI-Lite (same clock):
  - Write: accept when awvalid and wvalid are both high and no bvalid is pending. awready and wready pulse for 1 cycle; bvalid follows the next cycle with bresp=OKAY. wstrb is honoured per byte on ctrl.
  - Read: arready pulses 1 cycle; rvalid follows next cycle with rresp=OKAY. Unmapped reads return 0; unmapped writes are ignored.
  - Simultaneous read and write are both served; a write and a counter increment in the same cycle -> clear wins.
- Register map (byte address; per-channel base = 0x10 + 0x10*c):
  - +0x0 ctrl: bit0 enable, bits[8+:AXIS_ID_WIDTH] tid
  - +0x4 pkt_count
  - +0x8 trunc_count
  - +0xC drop_count
  - 0x00: read-only NUM_CHAN

Optional Feature:
- NET_PASSTHROUGH_BYTE_COUNT_EN:
  - Defined: adds a per-channel 32-bit saturating byte counter at 0x90 + 4*c, incremented by popcount(tkeep) of each forwarded beat; write clears it.
  - Undefined: no counter logic; those addresses read 0.

Decomposition:
- Package net_passthrough_pkg: chan_state_e (IDLE, PASS, DISCARD, DROP), register offset localparams, counter width, the MAX_BEATS function.
- Sub-module net_passthrough_chan (FSM + skid + counters), generated NUM_CHAN times. The top level holds the AXI-Lite decode and register read mux.

Test Plan:
- Single channel, 64-bit bus, tready=1, 3-beat packet with tkeep 0xFF,0xFF,0x0F -> identical beats out 1 cycle later, tid=0, pkt_count=1.
- 200-beat packet with MAX_PACKET_LENGTH=1522 (MAX_BEATS=191) -> 191 beats out, last with tlast=1; 9 beats consumed with no output; trunc_count=1.
- Write ctrl[0]=0 during a PASS packet -> that packet completes in full; next 2-beat packet is dropped with tready=1, no tvalid, drop_count=1.
- Random tready at 50% on ch1 while ch0 streams -> no beat lost or duplicated on either channel; each channel's ordering is preserved.
- Assert areset mid-packet, then send a 1-beat packet -> first output is that single beat with tlast=1; counters read 0 before it.
- With NET_PASSTHROUGH_BYTE_COUNT_EN defined, send 3-beat packet with tkeep 0xFF,0xFF,0x0F -> byte counter at 0x90 reads 20; write to it -> reads 0.
